uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       irx,
  output logic [7:0] odata,
  output logic       ovalid,
  output logic       oframe_err,
`ifdef UART_RX_PARITY_EN
  output logic       operr,
`endif
  output logic       obusy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q;
  logic            rx_s_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            perr_q, perr_d;
`endif

  // Synchronizer flops reset high so a released reset never looks like a start edge.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      sync1_q     <= irx;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      perr_q      <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    perr_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end

      // Timer restarts at every sample point, so all later samples stay mid-bit.
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          par_bad_d = ^{shift_q, rx_s_q};
          state_d   = S_STOP;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
`endif

      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end

      // A held-low line (break) must not be mistaken for a new start bit.
      S_WAIT_IDLE: begin
        timer_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign odata      = data_q;
  assign ovalid     = valid_q;
  assign oframe_err = frame_err_q;
  assign obusy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign operr      = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard testbench for uart_rx at CLKS_PER_BIT = 8 with randomized frames.
// Define UART_RX_PARITY_EN for both files to exercise the parity build.
module tb_uart_rx;

   localparam int CPB = 8;

   logic       clk;
   logic       rstN;
   logic       irx;
   logic [7:0] odata;
   logic       ovalid;
   logic       oframeErr;
   logic       obusy;
`ifdef UART_RX_PARITY_EN
   logic       operr;
`endif

   typedef struct {
      bit         isErr;
      logic [7:0] data;
      bit         perr;
   } expT;

   expT        expQ[$];
   logic [7:0] lastData;
   int         compared;
   int         mismatched;
   int         cycleCnt;
   int         frameStartCycle;
   int         lastValidCycle;
   int         validCount;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .iclk      (clk),
      .irst_n    (rstN),
      .irx       (irx),
      .odata     (odata),
      .ovalid    (ovalid),
      .oframe_err(oframeErr),
`ifdef UART_RX_PARITY_EN
      .operr     (operr),
`endif
      .obusy     (obusy)
   );

   // Free-running 100 MHz clock and a cycle counter used for latency measurement.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Hard stop in case anything wedges; reported as a failure before quitting.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single point where every comparison is counted and reported.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Holds the serial line at a level for a number of clocks, changing just after a rising edge.
   task automatic applyStimulus(input logic level, input int cycles);
      irx = level;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Transmits one frame and records what the receiver should report for it.
   task automatic sendFrameP(input logic [7:0] b, input logic stopBit, input logic parBit);
      expT e;
      e.isErr = !stopBit;
      e.data  = stopBit ? b : lastData;
      e.perr  = (^{b, parBit}) != 1'b0;
      if (stopBit) lastData = b;
      expQ.push_back(e);
      frameStartCycle = cycleCnt;
      applyStimulus(1'b0, CPB);
      for (int i = 0; i < 8; i++) applyStimulus(b[i], CPB);
`ifdef UART_RX_PARITY_EN
      applyStimulus(parBit, CPB);
`endif
      applyStimulus(stopBit, CPB);
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit);
      sendFrameP(b, stopBit, ^b);
   endtask

   // Monitor: every output pulse from the DUT is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rstN) begin
         if (ovalid && oframeErr) begin
            checkOutput("valid_and_frame_err_together", 32'd1, 32'd0);
         end
         if (ovalid || oframeErr) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_pulse", {30'd0, oframeErr, ovalid}, 32'd0);
            end else begin
               expT e;
               e = expQ.pop_front();
               checkOutput(ovalid ? "pulse_kind_valid" : "pulse_kind_frame_err",
                           {31'd0, oframeErr}, {31'd0, e.isErr});
               checkOutput("odata", {24'd0, odata}, {24'd0, e.data});
`ifdef UART_RX_PARITY_EN
               if (ovalid) checkOutput("operr", {31'd0, operr}, {31'd0, e.perr});
`endif
            end
         end
         if (ovalid) begin
            lastValidCycle = cycleCnt;
            validCount++;
         end
      end
   end

   // Directed scenarios first, then a block of randomized frames.
   initial begin
      int startValids;
      int n;
      compared       = 0;
      mismatched     = 0;
      cycleCnt       = 0;
      validCount     = 0;
      lastValidCycle = 0;
      lastData       = 8'h00;
      irx            = 1'b1;
      rstN           = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 3);
      checkOutput("reset_odata", {24'd0, odata}, 32'h0);
      checkOutput("reset_ovalid", {31'd0, ovalid}, 32'd0);
      checkOutput("reset_frame_err", {31'd0, oframeErr}, 32'd0);
      checkOutput("reset_obusy", {31'd0, obusy}, 32'd0);
      rstN = 1'b1;
      applyStimulus(1'b1, 2 * CPB);

      $display("[TB] single frame 0xA5");
      startValids = validCount;
      sendFrame(8'hA5, 1'b1);
      applyStimulus(1'b1, 2 * CPB);
      checkOutput("a5_pulse_count", validCount - startValids, 32'd1);
      compared++;
      if (lastValidCycle - frameStartCycle < 78 || lastValidCycle - frameStartCycle > 84) begin
         mismatched++;
         $display("[TB] FAIL latency: got %0d cycles expected 78..84", lastValidCycle - frameStartCycle);
      end
      checkOutput("a5_queue_drained", expQ.size(), 32'd0);

      $display("[TB] start-bit glitch");
      applyStimulus(1'b0, 3);
      n = 0;
      irx = 1'b1;
      while (obusy && n < 6) begin
         applyStimulus(1'b1, 1);
         n++;
      end
      checkOutput("glitch_obusy_low", {31'd0, obusy}, 32'd0);
      applyStimulus(1'b1, 2 * CPB);
      checkOutput("glitch_odata_kept", {24'd0, odata}, 32'hA5);

      $display("[TB] framing error then break");
      sendFrame(8'h3C, 1'b0);
      applyStimulus(1'b0, 40);
      checkOutput("break_obusy_high", {31'd0, obusy}, 32'd1);
      checkOutput("break_odata_kept", {24'd0, odata}, 32'hA5);
      checkOutput("break_queue_drained", expQ.size(), 32'd0);
      applyStimulus(1'b1, 4);
      checkOutput("break_release_obusy", {31'd0, obusy}, 32'd0);
      applyStimulus(1'b1, 2 * CPB);

      $display("[TB] back-to-back 0x00 0xFF 0x55");
      sendFrame(8'h00, 1'b1);
      sendFrame(8'hFF, 1'b1);
      sendFrame(8'h55, 1'b1);
      applyStimulus(1'b1, 2 * CPB);
      checkOutput("b2b_queue_drained", expQ.size(), 32'd0);

      $display("[TB] reset during bit 4 of 0x81");
      applyStimulus(1'b0, CPB);
      applyStimulus(1'b1, CPB);
      for (int i = 1; i < 4; i++) applyStimulus(1'b0, CPB);
      applyStimulus(1'b0, 3);
      rstN = 1'b0;
      applyStimulus(1'b1, 2);
      rstN = 1'b1;
      expQ.delete();
      lastData = 8'h00;
      checkOutput("abort_odata_reset", {24'd0, odata}, 32'h0);
      checkOutput("abort_obusy", {31'd0, obusy}, 32'd0);
      applyStimulus(1'b1, 2 * CPB);
      sendFrame(8'h42, 1'b1);
      applyStimulus(1'b1, 2 * CPB);
      checkOutput("abort_then_0x42", {24'd0, odata}, 32'h42);
      checkOutput("abort_queue_drained", expQ.size(), 32'd0);

`ifdef UART_RX_PARITY_EN
      $display("[TB] parity checks on 0x07");
      sendFrameP(8'h07, 1'b1, 1'b0);
      applyStimulus(1'b1, 2 * CPB);
      sendFrameP(8'h07, 1'b1, 1'b1);
      applyStimulus(1'b1, 2 * CPB);
`endif

      $display("[TB] randomized frames");
      for (int k = 0; k < 24; k++) begin
         logic [7:0] b;
         logic       stopBit;
         b       = 8'($urandom_range(0, 255));
         stopBit = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
         sendFrameP(b, stopBit, 1'($urandom_range(0, 1)));
`else
         sendFrame(b, stopBit);
`endif
         if (!stopBit) begin
            applyStimulus(1'b0, $urandom_range(0, 20));
            applyStimulus(1'b1, 3 * CPB);
         end else begin
            applyStimulus(1'b1, $urandom_range(0, 3));
         end
      end
      applyStimulus(1'b1, 3 * CPB);
      checkOutput("final_queue_drained", expQ.size(), 32'd0);
      checkOutput("final_odata", {24'd0, odata}, {24'd0, lastData});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
